// File: rtl/hazard_flush_ctrl_if.sv
// Decode/EX hazard bus between the pipeline datapath and the hazard/flush controller.
// Pure wiring, no latency.
// No backpressure of its own; stall_decode is the hold signal carried back to the pipeline.
interface hazard_flush_ctrl_if;
    logic        decode_output_valid;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [4:0]  reg_rd_id;
    logic        reg_write;
    logic        is_load;
    logic        squash_after_J;
    logic        squash_after_JALR;
    logic        resolve;
    logic        select_target_pc;
    logic        stall_decode;
    logic        flush_fetch;
    logic        flush_decode;
    logic [1:0]  fwd_rs1_sel;
    logic [1:0]  fwd_rs2_sel;
    logic [15:0] stall_count;

    // Pipeline side: drives decode/EX status, receives hazard controls.
    modport master (
        output decode_output_valid, rs1_id, rs2_id, reg_rd_id, reg_write, is_load,
               squash_after_J, squash_after_JALR, resolve, select_target_pc,
        input  stall_decode, flush_fetch, flush_decode, fwd_rs1_sel, fwd_rs2_sel, stall_count
    );

    // Controller side.
    modport slave (
        input  decode_output_valid, rs1_id, rs2_id, reg_rd_id, reg_write, is_load,
               squash_after_J, squash_after_JALR, resolve, select_target_pc,
        output stall_decode, flush_fetch, flush_decode, fwd_rs1_sel, fwd_rs2_sel, stall_count
    );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Load-use stall, operand forwarding select and fetch/decode flush window generator.
// Stall/forward are combinational from decode; flush outputs are registered (one cycle after the trigger).
// Asserts stall_decode to hold fetch/decode on a load-use hazard; a pending flush always overrides the stall.
module hazard_flush_ctrl (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_flush_ctrl_if.slave   hz
);

    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_load;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [1:0]  flush_cnt;
    logic [1:0]  flush_cnt_nxt;
    logic [15:0] stall_cnt;
    logic        flush_active;
    logic        stall;
    logic        squash_ok;
    logic [1:0]  rs1_sel;
    logic [1:0]  rs2_sel;

    assign flush_active = (flush_cnt != 2'd0);

    // A load in EX whose result decode needs cannot be forwarded in time; flush takes precedence.
    assign stall = hz.decode_output_valid & ex_valid & ex_load &
                   ((hz.rs1_id == ex_rd) | (hz.rs2_id == ex_rd)) & ~flush_active;

    // Jump squashes only count for a real instruction that is actually leaving decode.
    assign squash_ok = hz.decode_output_valid & ~stall;

    // Forwarding: youngest producer (EX, non-load) first, then MEM; x0 always reads the regfile.
    always_comb begin
        rs1_sel = 2'b00;
        rs2_sel = 2'b00;
        if (hz.rs1_id != 5'd0) begin
            if (ex_valid && (hz.rs1_id == ex_rd) && !ex_load) begin
                rs1_sel = 2'b01;
            end else if (mem_valid && (hz.rs1_id == mem_rd)) begin
                rs1_sel = 2'b10;
            end
        end
        if (hz.rs2_id != 5'd0) begin
            if (ex_valid && (hz.rs2_id == ex_rd) && !ex_load) begin
                rs2_sel = 2'b01;
            end else if (mem_valid && (hz.rs2_id == mem_rd)) begin
                rs2_sel = 2'b10;
            end
        end
    end

    // Flush window length: redirect and JALR squash open two cycles, JAL one; otherwise count down.
    always_comb begin
        flush_cnt_nxt = flush_active ? (flush_cnt - 2'd1) : 2'd0;
        if (hz.resolve && hz.select_target_pc) begin
            flush_cnt_nxt = 2'd2;
        end else if (squash_ok && hz.squash_after_JALR) begin
            flush_cnt_nxt = 2'd2;
        end else if (squash_ok && hz.squash_after_J) begin
            flush_cnt_nxt = 2'd1;
        end
    end

    // Scoreboard advance: decode enters EX unless stalled or flushed (then a bubble), EX moves to MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_rd     <= 5'd0;
            ex_load   <= 1'b0;
            mem_valid <= 1'b0;
            mem_rd    <= 5'd0;
        end else begin
            mem_valid <= ex_valid;
            mem_rd    <= ex_rd;
            if (!stall && !flush_active) begin
                ex_valid <= hz.decode_output_valid & hz.reg_write & (hz.reg_rd_id != 5'd0);
                ex_rd    <= hz.reg_rd_id;
                ex_load  <= hz.is_load;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

    // Flush window counter and saturating stall statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= 2'd0;
            stall_cnt <= 16'd0;
        end else begin
            flush_cnt <= flush_cnt_nxt;
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign hz.stall_decode = stall;
    assign hz.flush_fetch  = flush_active;
    assign hz.flush_decode = flush_active;
    assign hz.fwd_rs1_sel  = rs1_sel;
    assign hz.fwd_rs2_sel  = rs2_sel;
    assign hz.stall_count  = stall_cnt;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: directed vectors, a cycle-level reference model and literal spot checks.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The model tracks older in-flight instructions and the flush window as an absolute end cycle.
module tb_hazard_flush_ctrl;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    hazard_flush_ctrl_if hz ();

    hazard_flush_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic       wr;
        logic [4:0] rd;
        logic       ld;
    } instr_t;

    // older[0] = instruction one stage ahead of decode, older[1] = two stages ahead
    instr_t older [2];
    int     cyc       = 0;
    int     flush_end = -1;
    int     m_stalls  = 0;

    function automatic bit m_flush();
        return cyc <= flush_end;
    endfunction

    function automatic bit m_stall();
        bit uses;
        uses = (hz.rs1_id == older[0].rd) || (hz.rs2_id == older[0].rd);
        return hz.decode_output_valid && older[0].wr && older[0].ld && uses && !m_flush();
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (older[0].wr && older[0].rd == rs && !older[0].ld) return 2'b01;
        if (older[1].wr && older[1].rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        older[0] = '{1'b0, 5'd0, 1'b0};
        older[1] = '{1'b0, 5'd0, 1'b0};
    end

    // Model state update on each rising edge; asynchronous reset clears everything.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            cyc       = 0;
            flush_end = -1;
            m_stalls  = 0;
            older[0]  = '{1'b0, 5'd0, 1'b0};
            older[1]  = '{1'b0, 5'd0, 1'b0};
        end else begin
            automatic bit s   = m_stall();
            automatic bit f   = m_flush();
            automatic int win = 0;
            if (hz.resolve && hz.select_target_pc) win = 2;
            else if (hz.decode_output_valid && !s && hz.squash_after_JALR) win = 2;
            else if (hz.decode_output_valid && !s && hz.squash_after_J) win = 1;
            if (win > 0 && cyc + win > flush_end) flush_end = cyc + win;
            older[1] = older[0];
            if (s || f) begin
                older[0].wr = 1'b0;
            end else begin
                older[0].wr = hz.decode_output_valid && hz.reg_write && (hz.reg_rd_id != 5'd0);
                older[0].rd = hz.reg_rd_id;
                older[0].ld = hz.is_load;
            end
            if (s) m_stalls++;
            cyc++;
        end
    end

    // Compare every out-of-reset cycle on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("model stall_decode", {15'd0, hz.stall_decode}, {15'd0, m_stall()});
            chk("model flush_fetch",  {15'd0, hz.flush_fetch},  {15'd0, m_flush()});
            chk("model flush_decode", {15'd0, hz.flush_decode}, {15'd0, m_flush()});
            chk("model fwd_rs1_sel",  {14'd0, hz.fwd_rs1_sel},  {14'd0, m_fwd(hz.rs1_id)});
            chk("model fwd_rs2_sel",  {14'd0, hz.fwd_rs2_sel},  {14'd0, m_fwd(hz.rs2_id)});
            chk("model stall_count",  hz.stall_count,
                (m_stalls > 65535) ? 16'hFFFF : 16'(m_stalls));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic ld,
                          input logic j, input logic jalr, input logic res, input logic sel);
        hz.decode_output_valid = dv;
        hz.rs1_id              = rs1;
        hz.rs2_id              = rs2;
        hz.reg_rd_id           = rd;
        hz.reg_write           = rw;
        hz.is_load             = ld;
        hz.squash_after_J      = j;
        hz.squash_after_JALR   = jalr;
        hz.resolve             = res;
        hz.select_target_pc    = sel;
    endtask

    task automatic idle();
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flush(input string name, input logic exp);
        chk({name, " flush_fetch"},  {15'd0, hz.flush_fetch},  {15'd0, exp});
        chk({name, " flush_decode"}, {15'd0, hz.flush_decode}, {15'd0, exp});
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " stall_decode"}, {15'd0, hz.stall_decode}, 16'd0);
        chk_flush(name, 1'b0);
        chk({name, " fwd_rs1_sel"},  {14'd0, hz.fwd_rs1_sel}, 16'd0);
        chk({name, " fwd_rs2_sel"},  {14'd0, hz.fwd_rs2_sel}, 16'd0);
        chk({name, " stall_count"},  hz.stall_count, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        hz.rs1_id = 5'd5;
        hz.rs2_id = 5'd5;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle();
        tick();

        // Load-use: load x5, then consumer of x5 stalls once and takes MEM forwarding.
        set_in(1, 5'd0, 5'd0, 5'd5, 1, 1, 0, 0, 0, 0);
        #2 chk("lu load stall", {15'd0, hz.stall_decode}, 16'd0);
        tick();
        set_in(1, 5'd5, 5'd0, 5'd9, 1, 0, 0, 0, 0, 0);
        #2 chk("lu use stall", {15'd0, hz.stall_decode}, 16'd1);
        chk("lu use count before", hz.stall_count, 16'd0);
        tick();
        #2 chk("lu held stall", {15'd0, hz.stall_decode}, 16'd0);
        chk("lu held fwd_rs1", {14'd0, hz.fwd_rs1_sel}, 16'd2);
        chk("lu stall_count", hz.stall_count, 16'd1);
        tick();
        idle();
        tick();

        // ALU producer x7: EX forward, then MEM forward one cycle later.
        set_in(1, 5'd0, 5'd0, 5'd7, 1, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 5'd0, 5'd7, 5'd3, 1, 0, 0, 0, 0, 0);
        #2 chk("alu stall", {15'd0, hz.stall_decode}, 16'd0);
        chk("alu fwd_rs2 ex", {14'd0, hz.fwd_rs2_sel}, 16'd1);
        tick();
        set_in(1, 5'd0, 5'd7, 5'd0, 0, 0, 0, 0, 0, 0);
        #2 chk("alu fwd_rs2 mem", {14'd0, hz.fwd_rs2_sel}, 16'd2);
        tick();
        // x0 destination never forwards.
        set_in(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 5'd0, 5'd0, 5'd4, 1, 0, 0, 0, 0, 0);
        #2 chk("x0 fwd_rs1", {14'd0, hz.fwd_rs1_sel}, 16'd0);
        tick();
        idle();
        tick();
        tick();

        // Taken redirect: two flush cycles; resolve alone: none.
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1);
        #2 chk_flush("redir N", 1'b0);
        tick();
        idle();
        #2 chk_flush("redir N+1", 1'b1);
        tick();
        #2 chk_flush("redir N+2", 1'b1);
        tick();
        #2 chk_flush("redir N+3", 1'b0);
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);
        tick();
        idle();
        #2 chk_flush("resolve only", 1'b0);
        tick();

        // JAL: one flush cycle; JAL+JALR: two; squash without valid decode: none.
        set_in(1, 5'd0, 5'd0, 5'd1, 1, 0, 1, 0, 0, 0);
        tick();
        idle();
        #2 chk_flush("jal N+1", 1'b1);
        tick();
        #2 chk_flush("jal N+2", 1'b0);
        set_in(1, 5'd0, 5'd0, 5'd1, 1, 0, 1, 1, 0, 0);
        tick();
        idle();
        #2 chk_flush("jalr N+1", 1'b1);
        tick();
        #2 chk_flush("jalr N+2", 1'b1);
        tick();
        #2 chk_flush("jalr N+3", 1'b0);
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0);
        tick();
        idle();
        #2 chk_flush("squash invalid", 1'b0);
        tick();

        // Load-use inside a flush window: flush wins; a second redirect restarts the window.
        set_in(1, 5'd0, 5'd0, 5'd6, 1, 1, 0, 0, 1, 1);
        tick();
        set_in(1, 5'd6, 5'd0, 5'd8, 1, 0, 0, 0, 1, 1);
        #2 chk("coincide stall", {15'd0, hz.stall_decode}, 16'd0);
        chk_flush("coincide N+1", 1'b1);
        tick();
        idle();
        #2 chk_flush("coincide N+2", 1'b1);
        tick();
        #2 chk_flush("coincide N+3", 1'b1);
        tick();
        #2 chk_flush("coincide N+4", 1'b0);
        chk("coincide count", hz.stall_count, 16'd1);
        tick();

        // Back-to-back dependent loads stall every other cycle until the counter saturates.
        set_in(1, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0, 0, 0);
        repeat (2 * 65540 + 4) tick();
        idle();
        #2 chk("saturated count", hz.stall_count, 16'hFFFF);
        tick();

        // Reset in the middle of a flush window.
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1);
        tick();
        idle();
        hz.rs1_id = 5'd5;
        #2 chk_flush("pre-reset", 1'b1);
        rst_n = 1'b0;
        #1 chk_all_zero("async reset");
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        #2 chk_flush("post-reset", 1'b0);
        chk("post-reset count", hz.stall_count, 16'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
